// File: rtl/fu_scalar_ls_queue.sv
// Queued scalar load/store unit: captures sized memory ops into an in-order
// queue, issues them to the dcache one at a time and returns one response per
// op (tag, extended load data, fault flag). Misaligned or illegal-size ops
// never touch the cache and complete with fault=1.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high. valid must not depend on ready. On the request side req_ready only
// reflects queue occupancy. On the response side resp_valid and all resp_*
// fields stay stable until the transfer edge.
module fu_scalar_ls_queue #(
  parameter int WORD_W = 32,
  parameter int QDEPTH = 4,
  parameter int TAG_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [WORD_W-1:0] rs1,
  input  logic [WORD_W-1:0] imm,
  input  logic [WORD_W-1:0] rs2,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [TAG_W-1:0]  resp_tag,
  output logic [WORD_W-1:0] resp_data,
  output logic              resp_fault,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic [3:0]        dmembyteen,
  input  logic [WORD_W-1:0] dmem_in,
  input  logic              dhit_in,
  output logic              busy,
  output logic              dbg_state
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state, state_n;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              push, pop, resp_load;

  logic [WORD_W-1:0] q_ea    [QDEPTH];
  logic [WORD_W-1:0] q_data  [QDEPTH];
  logic [TAG_W-1:0]  q_tag   [QDEPTH];
  logic [1:0]        q_size  [QDEPTH];
  logic              q_store [QDEPTH];
  logic              q_uns   [QDEPTH];
  logic              q_fault [QDEPTH];

  logic [WORD_W-1:0] enq_ea;
  logic              enq_fault;
  logic [WORD_W-1:0] h_ea, h_data, ld_raw, ld_ext, resp_data_n;
  logic [TAG_W-1:0]  h_tag;
  logic [1:0]        h_size;
  logic              h_store, h_uns, h_fault;

  assign enq_ea    = rs1 + imm;
  assign enq_fault = (req_size == 2'b11) ||
                     (req_size == 2'b01 && enq_ea[0]) ||
                     (req_size == 2'b10 && enq_ea[1:0] != 2'b00);

  // No bypass: a full queue refuses even when the head pops this cycle.
  assign req_ready = (count < CW'(QDEPTH));
  assign push      = req_valid && req_ready && !flush;
  assign busy      = (count != '0) || resp_valid;
  assign dbg_state = (state == ACCESS);

  assign h_ea    = q_ea[rd_ptr];
  assign h_data  = q_data[rd_ptr];
  assign h_tag   = q_tag[rd_ptr];
  assign h_size  = q_size[rd_ptr];
  assign h_store = q_store[rd_ptr];
  assign h_uns   = q_uns[rd_ptr];
  assign h_fault = q_fault[rd_ptr];

  // Queue payload storage; contents are only meaningful below count.
  always_ff @(posedge CLK) begin
    if (push) begin
      q_ea[wr_ptr]    <= enq_ea;
      q_data[wr_ptr]  <= rs2;
      q_tag[wr_ptr]   <= req_tag;
      q_size[wr_ptr]  <= req_size;
      q_store[wr_ptr] <= req_store;
      q_uns[wr_ptr]   <= req_unsigned;
      q_fault[wr_ptr] <= enq_fault;
    end
  end

  // Pointers and occupancy; flush empties the queue.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)        state <= IDLE;
    else if (flush) state <= IDLE;
    else            state <= state_n;
  end

  // Next state: faulted heads retire straight from IDLE; others go to the cache.
  always_comb begin
    state_n   = state;
    pop       = 1'b0;
    resp_load = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0 && !resp_valid) begin
          if (h_fault) begin
            pop       = 1'b1;
            resp_load = 1'b1;
          end else begin
            state_n = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (dhit_in) begin
          pop       = 1'b1;
          resp_load = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Cache request drive: held stable from the head entry for the whole access.
  always_comb begin
    dmemREN    = 1'b0;
    dmemWEN    = 1'b0;
    dmemaddr   = '0;
    dmemstore  = '0;
    dmembyteen = 4'b0000;
    if (state == ACCESS) begin
      dmemaddr = {h_ea[WORD_W-1:2], 2'b00};
      if (h_store) begin
        dmemWEN = 1'b1;
        case (h_size)
          2'b00: begin
            dmemstore  = {4{h_data[7:0]}};
            dmembyteen = 4'b0001 << h_ea[1:0];
          end
          2'b01: begin
            dmemstore  = {2{h_data[15:0]}};
            dmembyteen = 4'b0011 << h_ea[1:0];
          end
          default: begin
            dmemstore  = h_data;
            dmembyteen = 4'b1111;
          end
        endcase
      end else begin
        dmemREN = 1'b1;
      end
    end
  end

  // Load data alignment and sign/zero extension.
  always_comb begin
    ld_raw = dmem_in >> {h_ea[1:0], 3'b000};
    case (h_size)
      2'b00:   ld_ext = {{(WORD_W-8){!h_uns && ld_raw[7]}}, ld_raw[7:0]};
      2'b01:   ld_ext = {{(WORD_W-16){!h_uns && ld_raw[15]}}, ld_raw[15:0]};
      default: ld_ext = dmem_in;
    endcase
    resp_data_n = (h_fault || h_store) ? '0 : ld_ext;
  end

  // Response register: loaded only while empty, cleared on the taking edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      resp_valid <= 1'b0;
      resp_tag   <= '0;
      resp_data  <= '0;
      resp_fault <= 1'b0;
    end else if (flush) begin
      resp_valid <= 1'b0;
    end else if (resp_load) begin
      resp_valid <= 1'b1;
      resp_tag   <= h_tag;
      resp_data  <= resp_data_n;
      resp_fault <= h_fault;
    end else if (resp_valid && resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule
